// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bus and single-port RAM bus of the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t ramload;

  word_t ramaddr;
  word_t ramstore;
  logic  ramREN;
  logic  ramWEN;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;

  // Arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
    output ramaddr, ramstore, ramREN, ramWEN, ihit, dhit, iload, dload
  );

  // Requester / RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
    input  ramaddr, ramstore, ramREN, ramWEN, ihit, dhit, iload, dload
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single fixed-latency RAM port, alternating on contention.
// Optional stall counters are built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output word_t         istall_cnt,
  output word_t         dstall_cnt
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  arb_state_t state;
  arb_state_t next_state;
  logic [3:0] cnt;
  logic       last_d;
  logic       d_req;
  logic       last_cycle;

  assign d_req      = bus.dREN | bus.dWEN;
  assign last_cycle = (cnt == LAST_CNT);

  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ihit     = 1'b0;
    bus.dhit     = 1'b0;
    bus.iload    = '0;
    bus.dload    = '0;
    unique case (state)
      IDLE: begin
        // On contention the side that did not win last time gets the port
        if (d_req && (!bus.iREN || !last_d)) next_state = DACC;
        else if (bus.iREN)                   next_state = IACC;
      end
      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (last_cycle) begin
          bus.ihit   = 1'b1;
          bus.iload  = bus.ramload;
          next_state = IDLE;
        end
      end
      DACC: begin
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else if (last_cycle) begin
          bus.dhit   = 1'b1;
          bus.dload  = bus.ramload;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (next_state != IDLE) begin
          cnt    <= '0;
          last_d <= (next_state == DACC);
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_cnt <= '0;
      dstall_cnt <= '0;
    end else begin
      if (bus.iREN && !bus.ihit) istall_cnt <= sat_inc(istall_cnt);
      if (d_req && !bus.dhit)    dstall_cnt <= sat_inc(dstall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LAT=2 instance with hit scoreboard, LAT=3 instance with direct checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int L2 = 2;
  localparam int L3 = 3;

  logic CLK = 1'b0;
  logic nRST;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mem_arbiter_if bus2();
  mem_arbiter_if bus3();

`ifdef MEM_ARBITER_STATS_EN
  word_t istall2, dstall2, istall3, dstall3;
`endif

  mem_arbiter #(.LAT(L2)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .bus(bus2)
`ifdef MEM_ARBITER_STATS_EN
    , .istall_cnt(istall2), .dstall_cnt(dstall2)
`endif
  );

  mem_arbiter #(.LAT(L3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .bus(bus3)
`ifdef MEM_ARBITER_STATS_EN
    , .istall_cnt(istall3), .dstall_cnt(dstall3)
`endif
  );

  function automatic word_t ram_fn(input word_t a);
    if (a == 32'h40) return 32'h8C01_0004;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus2.ramload = ram_fn(bus2.ramaddr);
  assign bus3.ramload = ram_fn(bus3.ramaddr);

  typedef struct {
    bit    is_d;
    int    cyc;
    word_t data;
  } hit_t;

  hit_t sb[$];
  hit_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_hit(input bit is_d, input int at, input word_t data);
    hit_t e;
    e.is_d = is_d;
    e.cyc  = at;
    e.data = data;
    sb.push_back(e);
  endtask

  // Hit monitor for the LAT=2 instance
  always @(negedge CLK) begin
    check_eq("hit_excl", 32'(bus2.ihit & bus2.dhit), 32'd0);
    if (!bus2.ihit) check_eq("iload_zero", bus2.iload, 32'd0);
    if (!bus2.dhit) check_eq("dload_zero", bus2.dload, 32'd0);
    if (bus2.ihit || bus2.dhit) begin
      if (sb.size() == 0) begin
        check_eq("hit_unexpected", {30'd0, bus2.ihit, bus2.dhit}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("hit_kind", 32'(bus2.dhit), 32'(mon_e.is_d));
        check_eq("hit_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_eq("hit_data", mon_e.is_d ? bus2.dload : bus2.iload, mon_e.data);
      end
    end
  end

  task automatic do_access(input bit is_d, input bit rd, input bit wr,
                           input word_t addr, input word_t wdata);
    if (is_d) begin
      bus2.dREN = rd; bus2.dWEN = wr; bus2.daddr = addr; bus2.dstore = wdata;
    end else begin
      bus2.iREN = 1'b1; bus2.iaddr = addr;
    end
    push_hit(is_d, cyc + L2, ram_fn(addr));
    for (int k = 0; k <= L2; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        check_eq("idle_ren", 32'(bus2.ramREN), 32'd0);
        check_eq("idle_wen", 32'(bus2.ramWEN), 32'd0);
        check_eq("idle_addr", bus2.ramaddr, 32'd0);
        check_eq("idle_store", bus2.ramstore, 32'd0);
      end else begin
        check_eq("acc_addr", bus2.ramaddr, addr);
        check_eq("acc_ren", 32'(bus2.ramREN), is_d ? 32'(rd & ~wr) : 32'd1);
        check_eq("acc_wen", 32'(bus2.ramWEN), 32'(is_d & wr));
        if (is_d) check_eq("acc_store", bus2.ramstore, wdata);
      end
      step();
    end
    bus2.iREN = 1'b0; bus2.dREN = 1'b0; bus2.dWEN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    nRST = 1'b0;
    bus2.iREN = 1'b1; bus2.iaddr = 32'h66; bus2.dREN = 1'b1; bus2.dWEN = 1'b1;
    bus2.daddr = 32'h55; bus2.dstore = 32'h77;
    bus3.iREN = 1'b0; bus3.iaddr = '0; bus3.dREN = 1'b0; bus3.dWEN = 1'b0;
    bus3.daddr = '0; bus3.dstore = '0;

    // Outputs held at zero during reset even with requests present
    repeat (2) @(negedge CLK);
    check_eq("rst_ren", 32'(bus2.ramREN), 32'd0);
    check_eq("rst_wen", 32'(bus2.ramWEN), 32'd0);
    check_eq("rst_addr", bus2.ramaddr, 32'd0);
    check_eq("rst_store", bus2.ramstore, 32'd0);
    check_eq("rst_ihit", 32'(bus2.ihit), 32'd0);
    check_eq("rst_dhit", 32'(bus2.dhit), 32'd0);
    bus2.iREN = 1'b0; bus2.dREN = 1'b0; bus2.dWEN = 1'b0;
    step();
    nRST = 1'b1;
    step();

    do_access(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
`ifdef MEM_ARBITER_STATS_EN
    check_eq("dstall_cnt", dstall2, 32'd2);
    check_eq("istall_cnt", istall2, 32'd0);
`endif
    do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    do_access(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b1, 1'b1, 32'h180, 32'h1234_5678);

    // Contention from reset release: D, I, D
    nRST = 1'b0;
    bus2.iREN = 1'b1; bus2.iaddr = 32'h300; bus2.dREN = 1'b1; bus2.daddr = 32'h400;
    step();
    nRST = 1'b1;
    t0 = cyc;
    push_hit(1'b1, t0 + 2, ram_fn(32'h400));
    push_hit(1'b0, t0 + 5, ram_fn(32'h300));
    push_hit(1'b1, t0 + 8, ram_fn(32'h400));
    repeat (9) step();
    bus2.iREN = 1'b0; bus2.dREN = 1'b0;

    // Aborted data grant still counts as the last grant
    do_access(1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
    bus2.dREN = 1'b1; bus2.daddr = 32'h600;
    step();
    bus2.dREN = 1'b0;
    @(negedge CLK);
    check_eq("wd_dacc_addr", bus2.ramaddr, 32'h600);
    step();
    @(negedge CLK);
    check_eq("wd_idle_addr", bus2.ramaddr, 32'd0);
    check_eq("wd_idle_ren", 32'(bus2.ramREN), 32'd0);
    step();
    bus2.iREN = 1'b1; bus2.iaddr = 32'h610; bus2.dREN = 1'b1; bus2.daddr = 32'h620;
    t0 = cyc;
    push_hit(1'b0, t0 + 2, ram_fn(32'h610));
    push_hit(1'b1, t0 + 5, ram_fn(32'h620));
    repeat (6) step();
    bus2.iREN = 1'b0; bus2.dREN = 1'b0;
    step();

    // LAT=3: plain fetch
    bus3.iREN = 1'b1; bus3.iaddr = 32'h800;
    for (int k = 0; k <= L3; k++) begin
      @(negedge CLK);
      check_eq("l3_ihit", 32'(bus3.ihit), 32'(k == L3));
      if (k == L3) check_eq("l3_iload", bus3.iload, ram_fn(32'h800));
      step();
    end
    bus3.iREN = 1'b0;

    // LAT=3: fetch withdrawn in first access cycle
    bus3.iREN = 1'b1; bus3.iaddr = 32'h900;
    step();
    bus3.iREN = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check_eq("l3_wd_ihit", 32'(bus3.ihit), 32'd0);
      if (k == 2) check_eq("l3_wd_ren", 32'(bus3.ramREN), 32'd0);
      if (k == 2) check_eq("l3_wd_addr", bus3.ramaddr, 32'd0);
      step();
    end

    // LAT=3: reset while DACC cnt=1, then fresh read after release
    bus3.dREN = 1'b1; bus3.daddr = 32'hA00;
    repeat (2) step();
    nRST = 1'b0;
    @(negedge CLK);
    check_eq("mid_rst_ren", 32'(bus3.ramREN), 32'd0);
    check_eq("mid_rst_addr", bus3.ramaddr, 32'd0);
    check_eq("mid_rst_dhit", 32'(bus3.dhit), 32'd0);
    check_eq("mid_rst_dload", bus3.dload, 32'd0);
    step();
    nRST = 1'b1;
    for (int k = 0; k <= L3; k++) begin
      @(negedge CLK);
      check_eq("post_rst_dhit", 32'(bus3.dhit), 32'(k == L3));
      if (k == L3) check_eq("post_rst_dload", bus3.dload, ram_fn(32'hA00));
      step();
    end
    bus3.dREN = 1'b0;

    repeat (3) step();
    check_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
